// File: rtl/event_count_ctrl.sv
// Front-end controller for the 4-bit event counter: synchronizes and debounces the
// event and clear keys, adds hold-to-repeat and optional saturation, and emits one-cycle commands.
module event_count_ctrl #(
    parameter int unsigned DB_CYCLES     = 500000,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000,
    parameter bit          REPEAT_EN     = 1'b1,
    parameter bit          SATURATE      = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_n,
    input  logic       clr_n,
    input  logic       dir,
    input  logic       at_max,
    input  logic       at_min,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic       clr_pulse,
    output logic       held,
    output logic [2:0] state_o
);

    localparam int unsigned DB_W    = $clog2(DB_CYCLES);
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX);

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DB_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_PRESS_DB   = 3'd1,
        S_HELD       = 3'd2,
        S_REPEAT     = 3'd3,
        S_RELEASE_DB = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [1:0]       key_sync_q;
    logic [1:0]       clr_sync_q;
    logic             clr_prev_q;
    logic             inc_q, dec_q, clr_q, held_q;
    logic             key_s;
    logic             clr_fall_s;
    logic             event_s;
    logic             inc_d, dec_d, held_d;

    // Synchronizers preset to "released" so reset exit never looks like a press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_sync_q <= 2'b11;
            clr_sync_q <= 2'b11;
            clr_prev_q <= 1'b1;
        end else begin
            key_sync_q <= {key_sync_q[0], key_n};
            clr_sync_q <= {clr_sync_q[0], clr_n};
            clr_prev_q <= clr_sync_q[1];
        end
    end

    assign key_s      = ~key_sync_q[1];
    assign clr_fall_s = clr_prev_q & ~clr_sync_q[1];

    // FSM state and debounce/repeat counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            db_cnt_q  <= '0;
            rpt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            db_cnt_q  <= db_cnt_d;
            rpt_cnt_q <= rpt_cnt_d;
        end
    end

    // Next-state logic; event_s marks the edge that decides a command.
    always_comb begin
        state_d   = state_q;
        db_cnt_d  = db_cnt_q;
        rpt_cnt_d = rpt_cnt_q;
        event_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (key_s) begin
                    state_d  = S_PRESS_DB;
                    db_cnt_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PRESS_DB: begin
                if (!key_s) begin
                    state_d = S_IDLE;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = S_HELD;
                    rpt_cnt_d = '0;
                    event_s   = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            S_HELD: begin
                if (!key_s) begin
                    state_d  = S_RELEASE_DB;
                    db_cnt_d = '0;
                end else if (REPEAT_EN && (rpt_cnt_q == DELAY_LAST)) begin
                    state_d   = S_REPEAT;
                    rpt_cnt_d = '0;
                    event_s   = 1'b1;
                end else if (rpt_cnt_q != DELAY_LAST) begin
                    rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                end else begin
                    // Repeat disabled: park the counter at its limit.
                    rpt_cnt_d = rpt_cnt_q;
                end
            end
            S_REPEAT: begin
                if (!key_s) begin
                    state_d  = S_RELEASE_DB;
                    db_cnt_d = '0;
                end else if (rpt_cnt_q == PERIOD_LAST) begin
                    rpt_cnt_d = '0;
                    event_s   = 1'b1;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                end
            end
            S_RELEASE_DB: begin
                if (key_s) begin
                    state_d   = S_HELD;
                    rpt_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            default: begin
                state_d   = S_IDLE;
                db_cnt_d  = '0;
                rpt_cnt_d = '0;
            end
        endcase
    end

    // Clear wins over a coincident event; saturation only masks the pulse.
    always_comb begin
        inc_d  = event_s & ~dir & ~(SATURATE & at_max) & ~clr_fall_s;
        dec_d  = event_s & dir & ~(SATURATE & at_min) & ~clr_fall_s;
        held_d = (state_d == S_HELD) || (state_d == S_REPEAT) || (state_d == S_RELEASE_DB);
    end

    // Registered command outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inc_q  <= 1'b0;
            dec_q  <= 1'b0;
            clr_q  <= 1'b0;
            held_q <= 1'b0;
        end else begin
            inc_q  <= inc_d;
            dec_q  <= dec_d;
            clr_q  <= clr_fall_s;
            held_q <= held_d;
        end
    end

    assign inc_pulse = inc_q;
    assign dec_pulse = dec_q;
    assign clr_pulse = clr_q;
    assign held      = held_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_event_count_ctrl.sv
// Self-checking bench for event_count_ctrl: per-edge stimulus tables, expected outputs derived
// from press-run arithmetic (edge offsets of debounce, repeat delay and period).
module tb_event_count_ctrl;

    localparam int DB = 4;
    localparam int RD = 16;
    localparam int RP = 8;
    localparam int MAXE = 512;

    logic       clk;
    logic       rst;
    logic       key_n, clr_n, dir, at_max, at_min;
    logic       inc_pulse, dec_pulse, clr_pulse, held;
    logic [2:0] state_o;

    event_count_ctrl #(
        .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
        .REPEAT_EN(1'b1), .SATURATE(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .key_n(key_n), .clr_n(clr_n), .dir(dir),
        .at_max(at_max), .at_min(at_min), .inc_pulse(inc_pulse), .dec_pulse(dec_pulse),
        .clr_pulse(clr_pulse), .held(held), .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus per edge (index = edge number after reset release) and expectations after that edge.
    logic kn [0:MAXE-1];
    logic cn [0:MAXE-1];
    logic dv [0:MAXE-1];
    logic ax [0:MAXE-1];
    logic an [0:MAXE-1];
    logic ei [0:MAXE-1];
    logic ed [0:MAXE-1];
    logic ec [0:MAXE-1];
    logic eh [0:MAXE-1];
    int   es [0:MAXE-1];

    int    n_total = 0;
    int    n_pass  = 0;
    int    n_fail  = 0;
    string seg_name;
    int    cur_edge;
    bit    no_held_state;

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s/%s edge %0d: observed %0h expected %0h", seg_name, tag, cur_edge, obs, exp);
        end
    endtask

    task automatic clear_tables();
        for (int i = 0; i < MAXE; i++) begin
            kn[i] = 1'b1; cn[i] = 1'b1; dv[i] = 1'b0; ax[i] = 1'b0; an[i] = 1'b0;
            ei[i] = 1'b0; ed[i] = 1'b0; ec[i] = 1'b0; eh[i] = 1'b0; es[i] = -1;
        end
        no_held_state = 1'b0;
    endtask

    function automatic logic clr_at(input int i);
        return (i < 1) ? 1'b1 : cn[i];
    endfunction

    // A clean low run of N samples starting at edge e decides its first command at edge e+DB+2,
    // repeats after RD then every RP while still seen pressed (through edge e+N+1),
    // and holds until the release debounce completes at edge e+N+DB+2.
    task automatic build_expected(input int len);
        int k, e, n, d, hi;
        for (int i = 1; i <= len; i++)
            ec[i] = (clr_at(i - 2) == 1'b0) && (clr_at(i - 3) == 1'b1);
        k = 1;
        while (k <= len) begin
            if (kn[k] == 1'b0) begin
                e = k;
                n = 0;
                while ((e + n <= len) && (kn[e + n] == 1'b0)) n++;
                if (n >= DB + 1) begin
                    hi = (e + n + DB + 1 < len) ? e + n + DB + 1 : len;
                    for (int h = e + DB + 2; h <= hi; h++) eh[h] = 1'b1;
                    d = e + DB + 2;
                    while ((d <= e + n + 1) && (d <= len)) begin
                        ei[d] = !ec[d] && !dv[d] && !ax[d];
                        ed[d] = !ec[d] && dv[d] && !an[d];
                        d = (d == e + DB + 2) ? d + RD : d + RP;
                    end
                end
                k = e + n;
            end else begin
                k++;
            end
        end
    endtask

    task automatic drive(input int k);
        key_n  = kn[k];
        clr_n  = cn[k];
        dir    = dv[k];
        at_max = ax[k];
        at_min = an[k];
    endtask

    // Reset, then replay the table; abort_at > 0 drops reset asynchronously after that edge.
    task automatic run_seg(input int len, input int abort_at);
        build_expected(len);
        rst = 1'b0;
        drive(1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        cur_edge = 0;
        check("rst_inc", {2'b00, inc_pulse}, 3'd0);
        check("rst_held", {2'b00, held}, 3'd0);
        check("rst_state", state_o, 3'd0);
        for (int k = 1; k <= len; k++) begin
            @(posedge clk);
            @(negedge clk);
            cur_edge = k;
            check("inc", {2'b00, inc_pulse}, {2'b00, ei[k]});
            check("dec", {2'b00, dec_pulse}, {2'b00, ed[k]});
            check("clr", {2'b00, clr_pulse}, {2'b00, ec[k]});
            check("held", {2'b00, held}, {2'b00, eh[k]});
            if (es[k] >= 0) check("state", state_o, es[k][2:0]);
            if (no_held_state) check("not_held_state", {2'b00, state_o == 3'd2}, 3'd0);
            if (k == abort_at) begin
                #2 rst = 1'b0;
                #1;
                check("async_inc", {2'b00, inc_pulse}, 3'd0);
                check("async_dec", {2'b00, dec_pulse}, 3'd0);
                check("async_held", {2'b00, held}, 3'd0);
                check("async_state", state_o, 3'd0);
                return;
            end
            drive(k + 1);
        end
    endtask

    initial begin
        int k, n, g;
        rst = 1'b0;
        key_n = 1'b1; clr_n = 1'b1; dir = 1'b0; at_max = 1'b0; at_min = 1'b0;

        seg_name = "clean_press";
        clear_tables();
        for (int i = 1; i <= 10; i++) kn[i] = 1'b0;
        es[2] = 0; es[3] = 1; es[6] = 1; es[7] = 2;
        run_seg(20, 0);

        seg_name = "bounce";
        clear_tables();
        for (int i = 0; i < 5; i++) begin kn[4*i+1] = 1'b0; kn[4*i+2] = 1'b0; end
        no_held_state = 1'b1;
        run_seg(30, 0);

        seg_name = "auto_repeat";
        clear_tables();
        for (int i = 1; i <= 56; i++) kn[i] = 1'b0;
        es[62] = 4; es[63] = 0;
        run_seg(70, 0);

        seg_name = "sat_max";
        clear_tables();
        for (int i = 1; i <= 30; i++) begin ax[i] = 1'b1; if (i <= 25) kn[i] = 1'b0; end
        run_seg(30, 0);

        seg_name = "sat_min";
        clear_tables();
        for (int i = 1; i <= 30; i++) begin dv[i] = 1'b1; an[i] = 1'b1; if (i <= 25) kn[i] = 1'b0; end
        run_seg(30, 0);

        seg_name = "dec_free";
        clear_tables();
        for (int i = 1; i <= 30; i++) begin dv[i] = 1'b1; ax[i] = 1'b1; if (i <= 25) kn[i] = 1'b0; end
        run_seg(30, 0);

        seg_name = "clr_priority";
        clear_tables();
        for (int i = 1; i <= 12; i++) kn[i] = 1'b0;
        for (int i = 5; i <= 15; i++) cn[i] = 1'b0;
        es[7] = 2; es[8] = 2;
        run_seg(15, 0);

        seg_name = "reset_mid_repeat";
        clear_tables();
        for (int i = 1; i <= 40; i++) kn[i] = 1'b0;
        es[31] = 3;
        run_seg(40, 31);

        seg_name = "after_reset";
        clear_tables();
        for (int i = 1; i <= 15; i++) kn[i] = 1'b0;
        es[6] = 1; es[7] = 2;
        run_seg(15, 0);

        for (int s = 0; s < 4; s++) begin
            seg_name = $sformatf("random%0d", s);
            clear_tables();
            for (int i = 1; i <= 300; i++) begin
                dv[i] = 1'($urandom_range(0, 1));
                ax[i] = ($urandom_range(0, 3) == 0);
                an[i] = ($urandom_range(0, 3) == 0);
                cn[i] = ($urandom_range(0, 24) != 0);
            end
            k = 1 + $urandom_range(0, 3);
            while (k <= 280) begin
                n = ($urandom_range(0, 1) == 0) ? $urandom_range(1, DB) : $urandom_range(DB + 1, 60);
                for (int i = k; (i < k + n) && (i <= 300); i++) kn[i] = 1'b0;
                g = (n > DB) ? $urandom_range(DB + 2, 15) : $urandom_range(1, 6);
                k = k + n + g;
            end
            run_seg(300, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
